// File: rtl/spi_lcd_sink_pkg.sv
// Shared definitions for the serial LCD receive model: panel command opcodes,
// decoder state encoding and default panel geometry / idle timeout.
package spi_lcd_sink_pkg;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam logic [7:0]  LCD_W_DEFAULT        = 8'd132;
    localparam logic [7:0]  LCD_H_DEFAULT        = 8'd162;
    localparam logic [15:0] IDLE_TIMEOUT_DEFAULT = 16'd4096;

    typedef enum logic [2:0] {
        StCmd,
        StCaset,
        StRaset,
        StRamwrHi,
        StRamwrLo,
        StSkip
    } dec_state_e;

endpackage

// File: rtl/spi_lcd_byte_rx.sv
// Byte receiver for the panel serial link: synchronises SCL/SDA/DC/RES into the
// system clock domain, shifts SDA MSB first on each SCL rise and emits a
// one-cycle byte pulse with the DC value sampled on the 8th rise.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   scl, sda, dc, res_n     raw panel signals (asynchronous)
//   panel_rst               synchronised panel reset (RES low)
//   byte_valid              one-cycle pulse when 8 bits have been received
//   byte_data, byte_is_data completed byte and its DC flag
//   timeout                 one-cycle pulse when a partial byte is discarded
module spi_lcd_byte_rx
    import spi_lcd_sink_pkg::*;
#(
    parameter logic [15:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    input  logic       dc,
    input  logic       res_n,
    output logic       panel_rst,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       timeout
);

    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic [1:0]  dc_sync;
    logic [1:0]  res_sync;
    logic        scl_prev;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] idle_cnt_q;
    logic        scl_rise;
    logic [7:0]  shift_next;

    assign scl_rise   = scl_sync[1] & ~scl_prev;
    assign panel_rst  = ~res_sync[1];
    assign shift_next = {shift_q[6:0], sda_sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync     <= '0;
            sda_sync     <= '0;
            dc_sync      <= '0;
            // Held in panel reset until RES has been seen high after system reset.
            res_sync     <= '0;
            scl_prev     <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[0], scl};
            sda_sync   <= {sda_sync[0], sda};
            dc_sync    <= {dc_sync[0], dc};
            res_sync   <= {res_sync[0], res_n};
            scl_prev   <= scl_sync[1];
            byte_valid <= 1'b0;
            timeout    <= 1'b0;
            if (panel_rst) begin
                bit_cnt_q  <= '0;
                idle_cnt_q <= '0;
            end else if (scl_rise) begin
                shift_q    <= shift_next;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                idle_cnt_q <= '0;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= shift_next;
                    byte_is_data <= dc_sync[1];
                end
            end else if (bit_cnt_q != 3'd0) begin
                // Stale bits are left in shift_q; eight fresh rises overwrite them all.
                if (idle_cnt_q == IDLE_TIMEOUT - 16'd1) begin
                    bit_cnt_q  <= '0;
                    idle_cnt_q <= '0;
                    timeout    <= 1'b1;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 16'd1;
                end
            end else begin
                idle_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_lcd_sink.sv
// Receive-side model of the 1.8" TFT serial interface. Decodes CASET, RASET,
// RAMWR, SLPOUT and DISPON from the byte stream and emits one pixel-write
// event (x, y, RGB565) per completed RAMWR pixel for loopback checking.
// Ports:
//   clk, rst_n_in                       system clock, async active-low reset
//   lcd_rst_n_in, lcd_clk_in,
//   lcd_data_in, lcd_dc_in              raw panel RES/SCL/SDA/DC
//   byte_valid_out, byte_data_out,
//   byte_is_data_out                    received byte stream
//   pix_valid_out, pix_x_out,
//   pix_y_out, pix_rgb_out              pixel-write stream
//   disp_on_out, sleep_out_out          panel status set by DISPON / SLPOUT
//   frame_err_out                       sticky timeout / parameter-underrun flag
module spi_lcd_sink
    import spi_lcd_sink_pkg::*;
#(
    parameter logic [7:0]  LCD_W        = LCD_W_DEFAULT,
    parameter logic [7:0]  LCD_H        = LCD_H_DEFAULT,
    parameter logic [15:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic        lcd_rst_n_in,
    input  logic        lcd_clk_in,
    input  logic        lcd_data_in,
    input  logic        lcd_dc_in,
    output logic        byte_valid_out,
    output logic [7:0]  byte_data_out,
    output logic        byte_is_data_out,
    output logic        pix_valid_out,
    output logic [7:0]  pix_x_out,
    output logic [7:0]  pix_y_out,
    output logic [15:0] pix_rgb_out,
    output logic        disp_on_out,
    output logic        sleep_out_out,
    output logic        frame_err_out
);

    logic       panel_rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_is_data;
    logic       rx_timeout;
    logic       byte_ok;

    spi_lcd_byte_rx #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_byte_rx (
        .clk          (clk),
        .rst_n        (rst_n_in),
        .scl          (lcd_clk_in),
        .sda          (lcd_data_in),
        .dc           (lcd_dc_in),
        .res_n        (lcd_rst_n_in),
        .panel_rst    (panel_rst),
        .byte_valid   (rx_valid),
        .byte_data    (rx_data),
        .byte_is_data (rx_is_data),
        .timeout      (rx_timeout)
    );

    // A byte registered just before RES went low must not leak out during reset.
    assign byte_ok = rx_valid & ~panel_rst;

    dec_state_e state_q, state_d;
    logic [7:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [7:0] start_q, start_d;
    logic [7:0] hi_q, hi_d;
    logic [1:0] param_idx_q, param_idx_d;
    logic       disp_q, disp_d, sleep_q, sleep_d, err_q, err_d;
    logic       pix_fire;

    always_comb begin
        state_d     = state_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        start_d     = start_q;
        hi_d        = hi_q;
        param_idx_d = param_idx_q;
        disp_d      = disp_q;
        sleep_d     = sleep_q;
        err_d       = err_q;
        pix_fire    = 1'b0;

        if (byte_ok) begin
            if (!rx_is_data) begin
                // Still collecting window params means the command cut them short.
                if (state_q == StCaset || state_q == StRaset) begin
                    err_d = 1'b1;
                end
                param_idx_d = '0;
                case (rx_data)
                    CMD_CASET: state_d = StCaset;
                    CMD_RASET: state_d = StRaset;
                    CMD_RAMWR: begin
                        state_d = StRamwrHi;
                        cur_x_d = xs_q;
                        cur_y_d = ys_q;
                    end
                    CMD_SLPOUT: begin
                        state_d = StCmd;
                        sleep_d = 1'b1;
                    end
                    CMD_DISPON: begin
                        state_d = StCmd;
                        disp_d  = 1'b1;
                    end
                    default: state_d = StSkip;
                endcase
            end else begin
                case (state_q)
                    StCaset, StRaset: begin
                        param_idx_d = param_idx_q + 2'd1;
                        if (param_idx_q == 2'd1) begin
                            start_d = rx_data;
                        end
                        if (param_idx_q == 2'd3) begin
                            if (state_q == StCaset) begin
                                xs_d = start_q;
                                xe_d = rx_data;
                            end else begin
                                ys_d = start_q;
                                ye_d = rx_data;
                            end
                            state_d = StCmd;
                        end
                    end
                    StRamwrHi: begin
                        hi_d    = rx_data;
                        state_d = StRamwrLo;
                    end
                    StRamwrLo: begin
                        pix_fire = 1'b1;
                        state_d  = StRamwrHi;
                        if (cur_x_q == xe_q) begin
                            cur_x_d = xs_q;
                            cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (rx_timeout && !panel_rst) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StCmd;
            xs_q        <= '0;
            xe_q        <= LCD_W - 8'd1;
            ys_q        <= '0;
            ye_q        <= LCD_H - 8'd1;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            start_q     <= '0;
            hi_q        <= '0;
            param_idx_q <= '0;
            disp_q      <= 1'b0;
            sleep_q     <= 1'b0;
            err_q       <= 1'b0;
        end else if (panel_rst) begin
            state_q     <= StCmd;
            xs_q        <= '0;
            xe_q        <= LCD_W - 8'd1;
            ys_q        <= '0;
            ye_q        <= LCD_H - 8'd1;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            start_q     <= '0;
            hi_q        <= '0;
            param_idx_q <= '0;
            disp_q      <= 1'b0;
            sleep_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            start_q     <= start_d;
            hi_q        <= hi_d;
            param_idx_q <= param_idx_d;
            disp_q      <= disp_d;
            sleep_q     <= sleep_d;
            err_q       <= err_d;
        end
    end

    assign byte_valid_out   = byte_ok;
    assign byte_data_out    = rx_data;
    assign byte_is_data_out = rx_is_data;
    assign pix_valid_out    = pix_fire;
    assign pix_x_out        = cur_x_q;
    assign pix_y_out        = cur_y_q;
    assign pix_rgb_out      = {hi_q, rx_data};
    assign disp_on_out      = disp_q;
    assign sleep_out_out    = sleep_q;
    assign frame_err_out    = err_q;

endmodule

// File: doc/spi_lcd_sink.md
Name: spi_lcd_sink

Overview:
- Receive-side model of the 1.8" TFT panel's 4-wire serial interface (RES, DC, SCL, SDA), driven by the panel driver's outputs.
- Oversamples SCL/SDA/DC on the system clock, assembles 9-bit words (DC plus 8 bits, MSB first) and decodes CASET, RASET, RAMWR, SLPOUT and DISPON.
- Emits a pixel-write stream (x, y, RGB565) that feeds a mirror frame buffer or bench scoreboard, which allows on-chip loopback checking of the LCD path.

Parameters:
LCD_W, 8'd132, panel width; reset value of the column end is LCD_W-1
LCD_H, 8'd162, panel height; reset value of the row end is LCD_H-1
IDLE_TIMEOUT, 16'd4096, clk cycles with no SCL rise before a partial byte is discarded

Ports:
clk  input  1  system clock, 100 MHz
rst_n_in  input  1  asynchronous active-low reset
lcd_rst_n_in  input  1  panel RES from driver; low = panel reset
lcd_clk_in  input  1  SCL from driver (asynchronous)
lcd_data_in  input  1  SDA from driver (asynchronous)
lcd_dc_in  input  1  DC from driver; 0 = command, 1 = data
byte_valid_out  output  1  one-cycle pulse when a byte completes
byte_data_out  output  8  completed byte
byte_is_data_out  output  1  DC value latched with the byte
pix_valid_out  output  1  one-cycle pulse per completed pixel
pix_x_out  output  8  pixel column
pix_y_out  output  8  pixel row
pix_rgb_out  output  16  RGB565 value, {high byte, low byte}
disp_on_out  output  1  set by DISPON (0x29), cleared by panel reset
sleep_out_out  output  1  set by SLPOUT (0x11), cleared by panel reset
frame_err_out  output  1  sticky; set on timeout discard or param underrun; cleared by panel reset

Behaviour:
- Reset (rst_n_in low): all outputs 0. Internal window registers reset to xs=0, xe=LCD_W-1, ys=0, ye=LCD_H-1. Decoder enters CMD.
- Input sync: SCL, SDA, DC and RES each pass through 2 flops. An SCL rise is detected as sync=1 while the previous sync=0.
- On each SCL rise: shift SDA into an 8-bit register, MSB first, and increment a 3-bit counter.
- On the 8th rise: latch DC and pulse byte_valid_out on the next cycle. Latency is 3 clk from the raw SCL edge to byte_valid_out.
- Panel reset (synced RES low): bit counter=0, decoder=CMD, window restored to reset values, disp_on, sleep_out and frame_err cleared, no pulses. This also applies in the middle of a byte or a pixel.
- Timeout: an idle counter runs while the bit counter is nonzero and clears on every SCL rise. When it reaches IDLE_TIMEOUT: bit counter=0, frame_err set, no byte emitted.
- Any command byte (DC=0) aborts the current decoder state and is decoded immediately.
- If the abort leaves CASET/RASET with fewer than 4 params, frame_err is set and the window is unchanged.
- Decoder FSM states: CMD, CASET, RASET, RAMWR_HI, RAMWR_LO, SKIP.
  - CMD: 0x2A -> CASET; 0x2B -> RASET; 0x2C -> RAMWR_HI with cursor x=xs, y=ys; 0x11 sets sleep_out; 0x29 sets disp_on; any other command -> SKIP.
  - CASET/RASET: collect 4 data bytes. Start = low byte of bytes 0-1, end = low byte of bytes 2-3 (high bytes ignored). Window updates atomically after byte 4, then -> CMD. Further data bytes in CMD are ignored.
  - RAMWR_HI: data byte is held as the high byte -> RAMWR_LO.
  - RAMWR_LO: data byte is the low byte. Pulse pix_valid with the current x/y, then -> RAMWR_HI.
  - Cursor advance after each pixel: if x==xe then x=xs and y increments, else x increments. If y==ye when it would increment, y=ys (frame wrap). All arithmetic is 8-bit.
  - SKIP: consumes data bytes until the next command.
- pix_valid_out fires in the same cycle as byte_valid_out of the low byte.
- Data bytes in CMD state produce byte_valid only.

Decomposition:
- Shared package: command opcodes (CMD_SLPOUT 8'h11, CMD_CASET 8'h2A, CMD_RASET 8'h2B, CMD_RAMWR 8'h2C, CMD_DISPON 8'h29), the decoder state encoding, and the LCD_W/LCD_H defaults.
- One natural sub-module, spi_lcd_byte_rx, holding sync, edge detect, shift, timeout and byte pulse. The top level holds the decoder, window and cursor.

Test Plan:
- Bytes 0x11 (DC=0) then 0x29 (DC=0), SCL period 20 clk -> two byte pulses with is_data=0; sleep_out=1, then disp_on=1; pix_valid never fires.
- 0x2A + data 00,02,00,04; 0x2B + 00,10,00,11; 0x2C + 6 pixels 0xF800 -> 6 pix pulses at (2,16) (3,16) (4,16) (2,17) (3,17) (4,17), rgb=F800.
- Continue with 1 more pixel 0x07E0 -> emitted at (2,16) (wrap to ys).
- Full-screen window (0..131, 0..161), 132*162 pixels of 0xFFE0 -> last pixel at (131,161), next at (0,0); pixel count 21384.
- 5 SCL rises then silence for 4096 clk -> no byte pulse, frame_err=1. Next full byte decodes correctly.
- RAMWR with high byte sent, then RES pulsed low for 4 clk -> no pix pulse, disp_on=0, frame_err=0, window back to 0..131/0..161. Then 0x2C + 0x001F -> pixel at (0,0).
